// File: rtl/seq_alu_pkg.sv
// Shared definitions for the sequential ALU.
// Holds the opcode constants and the FSM state type used by seq_alu and seq_alu_logic.
// Optional feature macro: SEQ_ALU_DIV_EN (enables the iterative unsigned divider in seq_alu).
package seq_alu_pkg;

  localparam int unsigned OP_AND   = 0;
  localparam int unsigned OP_OR    = 1;
  localparam int unsigned OP_ADD   = 2;
  localparam int unsigned OP_XOR   = 3;
  localparam int unsigned OP_MULTU = 4;
  localparam int unsigned OP_DIVU  = 5;
  localparam int unsigned OP_SUB   = 6;
  localparam int unsigned OP_SLT   = 7;
  localparam int unsigned OP_SLTU  = 8;
  localparam int unsigned OP_NOR   = 12;

  typedef enum logic [1:0] {
    StIdle,
    StMul,
    StDiv,
    StDone
  } state_e;

endpackage

// File: rtl/seq_alu_logic.sv
// Combinational single-cycle operation unit of the sequential ALU.
// Ports:
//   alu_ctl_i  operation code
//   a_i, b_i   operands
//   res_o      result; 0 for MULTU/DIVU and unrecognised codes
// Optional feature macro: none here (SEQ_ALU_DIV_EN only affects seq_alu).
module seq_alu_logic
  import seq_alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CTL_W = 4
) (
  input  logic [CTL_W-1:0] alu_ctl_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] res_o
);

  logic slt, sltu;

  assign slt  = $signed(a_i) < $signed(b_i);
  assign sltu = a_i < b_i;

  always_comb begin
    res_o = '0;
    case (alu_ctl_i)
      CTL_W'(OP_AND):  res_o = a_i & b_i;
      CTL_W'(OP_OR):   res_o = a_i | b_i;
      CTL_W'(OP_ADD):  res_o = a_i + b_i;
      CTL_W'(OP_XOR):  res_o = a_i ^ b_i;
      CTL_W'(OP_SUB):  res_o = a_i - b_i;
      CTL_W'(OP_SLT):  res_o = {{(WIDTH-1){1'b0}}, slt};
      CTL_W'(OP_SLTU): res_o = {{(WIDTH-1){1'b0}}, sltu};
      CTL_W'(OP_NOR):  res_o = ~(a_i | b_i);
      default:         res_o = '0;
    endcase
  end

endmodule

// File: rtl/seq_alu.sv
// Sequential ALU with iterative multiply (and optional divide) and HI/LO registers.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   in_valid, in_ready    request handshake (ready only when idle)
//   alu_ctl, a, b         opcode and operands, captured on accept
//   out_valid, out_ready  result handshake
//   result, zero          registered result and result==0 flag
//   hi, lo                architectural HI/LO registers (written by MULTU/DIVU only)
// Optional feature macro: SEQ_ALU_DIV_EN -- when defined, code 5 is a restoring DIVU;
// otherwise code 5 behaves as an unrecognised single-cycle opcode.
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CTL_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [CTL_W-1:0] alu_ctl,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CntW = $clog2(WIDTH);

  state_e             state_q, state_d;
  // work_q: {partial product, multiplier} for MUL, {remainder, dividend/quotient} for DIV
  logic [2*WIDTH-1:0] work_q, work_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               zero_q, zero_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;

  logic [WIDTH-1:0]   logic_res;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;

  seq_alu_logic #(
    .WIDTH(WIDTH),
    .CTL_W(CTL_W)
  ) u_logic (
    .alu_ctl_i(alu_ctl),
    .a_i      (a),
    .b_i      (b),
    .res_o    (logic_res)
  );

  // Shift-add step: add multiplicand into upper half when multiplier LSB set, then shift right.
  assign mul_sum  = {1'b0, work_q[2*WIDTH-1:WIDTH]} + (work_q[0] ? {1'b0, opnd_q} : '0);
  assign mul_next = {mul_sum, work_q[WIDTH-1:1]};

`ifdef SEQ_ALU_DIV_EN
  logic [WIDTH:0]     rem_sh, div_diff;
  logic [2*WIDTH-1:0] div_next;

  // Restoring step: shift next dividend bit into remainder, keep difference if no borrow.
  assign rem_sh   = {work_q[2*WIDTH-1:WIDTH], work_q[WIDTH-1]};
  assign div_diff = rem_sh - {1'b0, opnd_q};
  assign div_next = div_diff[WIDTH] ? {rem_sh[WIDTH-1:0], work_q[WIDTH-2:0], 1'b0}
                                    : {div_diff[WIDTH-1:0], work_q[WIDTH-2:0], 1'b1};
`endif

  always_comb begin
    state_d  = state_q;
    work_d   = work_q;
    opnd_d   = opnd_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    zero_d   = zero_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          if (alu_ctl == CTL_W'(OP_MULTU)) begin
            state_d = StMul;
            work_d  = {{WIDTH{1'b0}}, b};
            opnd_d  = a;
            cnt_d   = '0;
          end
`ifdef SEQ_ALU_DIV_EN
          else if (alu_ctl == CTL_W'(OP_DIVU)) begin
            if (b == '0) begin
              state_d  = StDone;
              lo_d     = '1;
              hi_d     = a;
              result_d = '1;
              zero_d   = 1'b0;
            end else begin
              state_d = StDiv;
              work_d  = {{WIDTH{1'b0}}, a};
              opnd_d  = b;
              cnt_d   = '0;
            end
          end
`endif
          else begin
            state_d  = StDone;
            result_d = logic_res;
            zero_d   = (logic_res == '0);
          end
        end
      end
      StMul: begin
        work_d = mul_next;
        cnt_d  = cnt_q + CntW'(1);
        if (cnt_q == CntW'(WIDTH - 1)) begin
          state_d  = StDone;
          hi_d     = mul_next[2*WIDTH-1:WIDTH];
          lo_d     = mul_next[WIDTH-1:0];
          result_d = mul_next[WIDTH-1:0];
          zero_d   = (mul_next[WIDTH-1:0] == '0);
        end
      end
`ifdef SEQ_ALU_DIV_EN
      StDiv: begin
        work_d = div_next;
        cnt_d  = cnt_q + CntW'(1);
        if (cnt_q == CntW'(WIDTH - 1)) begin
          state_d  = StDone;
          hi_d     = div_next[2*WIDTH-1:WIDTH];
          lo_d     = div_next[WIDTH-1:0];
          result_d = div_next[WIDTH-1:0];
          zero_d   = (div_next[WIDTH-1:0] == '0);
        end
      end
`endif
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      work_q   <= '0;
      opnd_q   <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      zero_q   <= 1'b1;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      work_q   <= work_d;
      opnd_q   <= opnd_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign result    = result_q;
  assign zero      = zero_q;
  assign hi        = hi_q;
  assign lo        = lo_q;

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu: scoreboard of expected responses fed by the stimulus
// tasks, drained by a monitor that checks each presented result. Honours SEQ_ALU_DIV_EN.
module tb_seq_alu;

  localparam int unsigned W  = 32;
  localparam int unsigned CW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic [CW-1:0] alu_ctl = '0;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic          in_ready, out_valid, zero;
  logic [W-1:0]  result, hi, lo;

  seq_alu #(
    .WIDTH(W),
    .CTL_W(CW)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .alu_ctl  (alu_ctl),
    .a        (a),
    .b        (b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result),
    .zero     (zero),
    .hi       (hi),
    .lo       (lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] res;
    logic         z;
    logic [W-1:0] h;
    logic [W-1:0] l;
    int           lat;
    int           acc;
  } exp_t;

  exp_t         q[$];
  int           checks = 0;
  int           errors = 0;
  int           cyc = 0;
  int           rdy_mode = 2;  // 0 random, 1 held low, 2 held high
  bit           seen = 1'b0;
  logic [W-1:0] m_hi = '0;
  logic [W-1:0] m_lo = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic bound_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s bound expired (cycle %0d)", name, cyc);
  endtask

  // Reference model: plain arithmetic on the opcode table; updates model HI/LO.
  function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] x,
                                 input logic [W-1:0] y);
    exp_t e;
    logic [2*W-1:0] p;
    e.lat = 1;
    e.acc = 0;
    e.res = '0;
    case (op)
      4'd0:  e.res = x & y;
      4'd1:  e.res = x | y;
      4'd2:  e.res = x + y;
      4'd3:  e.res = x ^ y;
      4'd6:  e.res = x - y;
      4'd7:  e.res = ($signed(x) < $signed(y)) ? W'(1) : W'(0);
      4'd8:  e.res = (x < y) ? W'(1) : W'(0);
      4'd12: e.res = ~(x | y);
      4'd4: begin
        p = {{W{1'b0}}, x} * {{W{1'b0}}, y};
        m_hi = p[2*W-1:W];
        m_lo = p[W-1:0];
        e.res = m_lo;
        e.lat = W + 1;
      end
`ifdef SEQ_ALU_DIV_EN
      4'd5: begin
        if (y == '0) begin
          m_lo = '1;
          m_hi = x;
        end else begin
          m_lo = x / y;
          m_hi = x % y;
          e.lat = W + 1;
        end
        e.res = m_lo;
      end
`endif
      default: e.res = '0;
    endcase
    e.z = (e.res == '0);
    e.h = m_hi;
    e.l = m_lo;
    return e;
  endfunction

  task automatic issue(input logic [3:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t e;
    int n = 0;
    @(negedge clk);
    alu_ctl = op;
    a = x;
    b = y;
    in_valid = 1'b1;
    while (!in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      bound_fail("issue_wait_ready");
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    e = model(op, x, y);
    e.acc = cyc;
    q.push_back(e);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) bound_fail("drain");
  endtask

  task automatic do_reset(input bit with_req);
    @(negedge clk);
    reset = 1'b1;
    if (with_req) begin
      alu_ctl = 4'd2;
      a = 32'd1;
      b = 32'd2;
      in_valid = 1'b1;
    end
    @(posedge clk);
    #1;
    q.delete();
    seen = 1'b0;
    m_hi = '0;
    m_lo = '0;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_result", 64'(result), 64'd0);
    chk("rst_zero", 64'(zero), 64'd1);
    chk("rst_hi", 64'(hi), 64'd0);
    chk("rst_lo", 64'(lo), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    in_valid = 1'b0;
  endtask

  // out_ready driver, changes well away from the sampling edges
  initial begin
    forever begin
      @(posedge clk);
      #2;
      case (rdy_mode)
        0:       out_ready = 1'($urandom_range(0, 1));
        1:       out_ready = 1'b0;
        default: out_ready = 1'b1;
      endcase
    end
  end

  // Monitor: busy <=> outstanding entry; every presented result checked against queue head
  always @(negedge clk) begin
    if (!reset) begin
      chk("in_ready", 64'(in_ready), 64'(q.size() == 0));
      if (out_valid) begin
        if (q.size() == 0) begin
          chk("unexpected_valid", 64'(out_valid), 64'd0);
        end else begin
          if (!seen) begin
            chk("latency", 64'(cyc - q[0].acc + 1), 64'(q[0].lat));
            seen = 1'b1;
          end
          chk("result", 64'(result), 64'(q[0].res));
          chk("zero", 64'(zero), 64'(q[0].z));
          chk("hi", 64'(hi), 64'(q[0].h));
          chk("lo", 64'(lo), 64'(q[0].l));
          if (out_ready) begin
            void'(q.pop_front());
            seen = 1'b0;
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] corner[4];
    logic [W-1:0] x, y;
    int n;
    corner[0] = '0;
    corner[1] = 32'd1;
    corner[2] = '1;
    corner[3] = 32'h8000_0000;

    // Reset state
    do_reset(1'b0);

    // Directed: wrap-around add, signed/unsigned compare
    issue(4'd2, 32'hFFFF_FFFF, 32'd1);
    issue(4'd7, 32'hFFFF_FFFF, 32'd1);
    issue(4'd8, 32'hFFFF_FFFF, 32'd1);
    issue(4'd12, 32'h0F0F_0000, 32'h0000_00F0);
    drain();

    // Directed: full-range multiply
    issue(4'd4, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    drain();
    chk("multu_hi", 64'(hi), 64'h0000_0000_FFFF_FFFE);
    chk("multu_lo", 64'(lo), 64'h0000_0000_0000_0001);

`ifdef SEQ_ALU_DIV_EN
    issue(4'd5, 32'd100, 32'd7);
    drain();
    chk("divu_lo", 64'(lo), 64'd14);
    chk("divu_hi", 64'(hi), 64'd2);
    issue(4'd5, 32'd5, 32'd0);
    drain();
    chk("divu0_lo", 64'(lo), 64'h0000_0000_FFFF_FFFF);
    chk("divu0_hi", 64'(hi), 64'd5);
`else
    issue(4'd5, 32'd100, 32'd7);
    drain();
    chk("code5_hi_kept", 64'(hi), 64'h0000_0000_FFFF_FFFE);
    chk("code5_lo_kept", 64'(lo), 64'd1);
`endif

    // Stall in DONE with a stray request pending; it must be taken only after release
    rdy_mode = 1;
    issue(4'd6, 32'd3, 32'd10);
    n = 0;
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) bound_fail("stall_wait_valid");
    alu_ctl = 4'd3;
    a = 32'hA5A5_0000;
    b = 32'h00FF_00FF;
    in_valid = 1'b1;
    repeat (5) @(negedge clk);
    rdy_mode = 2;
    issue(4'd3, 32'hA5A5_0000, 32'h00FF_00FF);
    drain();

    // Reset 10 cycles into a multiply aborts it and clears HI/LO
    issue(4'd4, $urandom | 32'h1, $urandom | 32'h1);
    repeat (10) @(negedge clk);
    do_reset(1'b0);
    // Reset dominates a simultaneous request
    do_reset(1'b1);
    repeat (3) @(negedge clk);

    // Randomised traffic with random back-pressure
    rdy_mode = 0;
    for (int i = 0; i < 60; i++) begin
      x = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : W'($urandom);
      y = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : W'($urandom);
      if ($urandom_range(0, 5) == 0) y = W'($urandom_range(1, 50));
      issue(4'($urandom_range(0, 15)), x, y);
    end
    rdy_mode = 2;
    drain();
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
